// File: rtl/mmu_cfg_init_master.sv
// Bus initiator that writes the cluster MMU SRAM/SCM sequential-section sizes after start_i.
// Define MMU_CFG_INIT_READBACK_EN to add the read-back-and-compare phase after both writes.
module mmu_cfg_init_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned ID_WIDTH       = 5,
  parameter int unsigned MASTER_ID      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [3:0]          sram_size_i,
  input  logic [3:0]          scm_size_i,
  output logic                req_o,
  output logic [31:0]         add_o,
  output logic                wen_o,
  output logic [31:0]         wdata_o,
  output logic [3:0]          be_o,
  output logic [ID_WIDTH-1:0] id_o,
  input  logic                gnt_i,
  input  logic                r_valid_i,
  input  logic [31:0]         r_rdata_i,
  input  logic                r_opc_i,
  input  logic [ID_WIDTH-1:0] r_id_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [3:0]          rb_sram_size_o,
  output logic [3:0]          rb_scm_size_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ID_WIDTH-1:0] MID     = ID_WIDTH'(MASTER_ID);

  typedef enum logic [3:0] {
    IDLE, WR0_REQ, WR0_RSP, WR1_REQ, WR1_RSP,
`ifdef MMU_CFG_INIT_READBACK_EN
    RD0_REQ, RD0_RSP, RD1_REQ, RD1_RSP,
`endif
    DONE, ERR
  } state_e;

`ifdef MMU_CFG_INIT_READBACK_EN
  localparam state_e WR_NEXT = RD0_REQ;

  // A read-back matches only if the upper bits are clear and the size field equals what was written.
  function automatic logic rb_ok(input logic [31:0] rdata, input logic [3:0] expv);
    return (rdata[31:4] == 28'd0) && (rdata[3:0] == expv);
  endfunction
`else
  localparam state_e WR_NEXT = DONE;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       sram_q, scm_q;
  logic             idle_like, rsp_acc, tmo;

  assign idle_like = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
  assign rsp_acc   = r_valid_i && (r_id_i == MID);
  assign tmo       = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Each request/response phase gets its own budget, restarted on every state change.
      if (idle_like || (state_d != state_q)) cnt_q <= '0;
      else                                   cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Sizes are pure data: only meaningful once a sequence has been started.
  always_ff @(posedge clk_i) begin
    if (idle_like && start_i) begin
      sram_q <= sram_size_i;
      scm_q  <= scm_size_i;
    end
  end

  always_comb begin
    state_d = state_q;
    req_o   = 1'b0;
    add_o   = '0;
    wen_o   = 1'b0;
    wdata_o = '0;
    be_o    = '0;
    id_o    = '0;
    case (state_q)
      IDLE, DONE, ERR: if (start_i) state_d = WR0_REQ;
      WR0_REQ: begin
        req_o = 1'b1; id_o = MID; add_o = BASE_ADDR; be_o = 4'b0001; wdata_o = {28'd0, sram_q};
        if (gnt_i)    state_d = WR0_RSP;
        else if (tmo) state_d = ERR;
      end
      WR0_RSP: begin
        if (rsp_acc)  state_d = r_opc_i ? ERR : WR1_REQ;
        else if (tmo) state_d = ERR;
      end
      WR1_REQ: begin
        req_o = 1'b1; id_o = MID; add_o = BASE_ADDR + 32'd4; be_o = 4'b0001; wdata_o = {28'd0, scm_q};
        if (gnt_i)    state_d = WR1_RSP;
        else if (tmo) state_d = ERR;
      end
      WR1_RSP: begin
        if (rsp_acc)  state_d = r_opc_i ? ERR : WR_NEXT;
        else if (tmo) state_d = ERR;
      end
`ifdef MMU_CFG_INIT_READBACK_EN
      RD0_REQ: begin
        req_o = 1'b1; id_o = MID; add_o = BASE_ADDR; wen_o = 1'b1; be_o = 4'b1111;
        if (gnt_i)    state_d = RD0_RSP;
        else if (tmo) state_d = ERR;
      end
      RD0_RSP: begin
        if (rsp_acc)  state_d = (r_opc_i || !rb_ok(r_rdata_i, sram_q)) ? ERR : RD1_REQ;
        else if (tmo) state_d = ERR;
      end
      RD1_REQ: begin
        req_o = 1'b1; id_o = MID; add_o = BASE_ADDR + 32'd4; wen_o = 1'b1; be_o = 4'b1111;
        if (gnt_i)    state_d = RD1_RSP;
        else if (tmo) state_d = ERR;
      end
      RD1_RSP: begin
        if (rsp_acc)  state_d = (r_opc_i || !rb_ok(r_rdata_i, scm_q)) ? ERR : DONE;
        else if (tmo) state_d = ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = !idle_like;
  assign done_o  = (state_q == DONE);
  assign error_o = (state_q == ERR);

`ifdef MMU_CFG_INIT_READBACK_EN
  logic [3:0] rb_sram_q, rb_scm_q;

  // Read-back values are captured even when they mismatch, so software can see what came back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rb_sram_q <= '0;
      rb_scm_q  <= '0;
    end else if (rsp_acc) begin
      if (state_q == RD0_RSP) rb_sram_q <= r_rdata_i[3:0];
      if (state_q == RD1_RSP) rb_scm_q  <= r_rdata_i[3:0];
    end
  end

  assign rb_sram_size_o = rb_sram_q;
  assign rb_scm_size_o  = rb_scm_q;
`else
  logic unused_rdata;
  assign unused_rdata   = ^r_rdata_i;
  assign rb_sram_size_o = '0;
  assign rb_scm_size_o  = '0;
`endif

endmodule
